// File: rtl/huc_rom_arb.sv
// rtl/huc_rom_arb.sv - cartridge ROM/PSRAM port arbiter: CPU priority, background DMA, fixed access timing
// Optional SF2 bank mapper enabled by HUC_ROM_ARB_SF2_EN.
module huc_rom_arb #(
  parameter int MEM_CYC      = 4,
  parameter int REC_CYC      = 1,
  parameter int DMA_MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [20:0] cpu_addr_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_oe_i,
  output logic [7:0]  cpu_dato_o,
  output logic        cpu_hit_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [19:0] dma_addr_i,
  input  logic [7:0]  dma_dati_i,
  output logic [7:0]  dma_dato_o,
  output logic        dma_ack_o,
  output logic        dma_starve_o,
  output logic [19:0] mem_addr_o,
  output logic [7:0]  mem_dati_o,
  input  logic [7:0]  mem_dato_i,
  output logic        mem_ce_o,
  output logic        mem_oe_o,
  output logic        mem_we_o
);

  localparam int              WW       = (DMA_MAX_WAIT < 2) ? 1 : $clog2(DMA_MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(DMA_MAX_WAIT);
  localparam logic [3:0]      ACC_LAST = 4'(MEM_CYC - 1);
  localparam logic [3:0]      REC_LAST = 4'(REC_CYC - 1);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, REC} state_t;

  state_t        state_q;
  logic [3:0]    cyc_q;
  logic          hit_q;
  logic          pend_q;
  logic [WW-1:0] wait_q;
  logic          cpu_trig;
  logic [19:0]   cpu_maddr;

  assign cpu_hit_o = cpu_ce_i & ~cpu_addr_i[20];

`ifdef HUC_ROM_ARB_SF2_EN
  logic [1:0] bank_q;
  logic       bank_wr;

  assign bank_wr   = cpu_ce_i & ~cpu_oe_i & (&cpu_addr_i[12:2]);
  assign cpu_trig  = cpu_hit_o & ~hit_q & ~bank_wr;
  // Only bit 0 of (bank + 1) survives the 20-bit truncation, and that is ~bank[0].
  assign cpu_maddr = cpu_addr_i[19] ? {~bank_q[0], cpu_addr_i[18:0]} : cpu_addr_i[19:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_q <= 2'd0;
    end else if (bank_wr) begin
      bank_q <= cpu_addr_i[1:0];
    end
  end
`else
  assign cpu_trig  = cpu_hit_o & ~hit_q;
  assign cpu_maddr = cpu_addr_i[19:0];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cyc_q        <= 4'd0;
      hit_q        <= 1'b0;
      pend_q       <= 1'b0;
      wait_q       <= '0;
      cpu_dato_o   <= 8'd0;
      dma_dato_o   <= 8'd0;
      dma_ack_o    <= 1'b0;
      dma_starve_o <= 1'b0;
      mem_addr_o   <= 20'd0;
      mem_dati_o   <= 8'd0;
      mem_ce_o     <= 1'b0;
      mem_oe_o     <= 1'b0;
      mem_we_o     <= 1'b0;
    end else begin
      hit_q     <= cpu_hit_o;
      dma_ack_o <= 1'b0;

      // A trigger that cannot be served now waits here; a second one is lost.
      if (cpu_trig) begin
        pend_q <= 1'b1;
      end

      if (dma_ack_o) begin
        wait_q <= '0;
      end else if (dma_req_i && state_q != DMA_ACC && wait_q != WAIT_MAX) begin
        wait_q <= wait_q + 1'b1;
        if ((wait_q + 1'b1) == WAIT_MAX) begin
          dma_starve_o <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (cpu_trig || pend_q) begin
            state_q    <= CPU_ACC;
            pend_q     <= 1'b0;
            cyc_q      <= 4'd0;
            mem_addr_o <= cpu_maddr;
            mem_ce_o   <= 1'b1;
            mem_oe_o   <= cpu_oe_i;
            mem_we_o   <= 1'b0;
          end else if (dma_req_i) begin
            state_q    <= DMA_ACC;
            cyc_q      <= 4'd0;
            mem_addr_o <= dma_addr_i;
            mem_dati_o <= dma_dati_i;
            mem_ce_o   <= 1'b1;
            mem_oe_o   <= ~dma_we_i;
            mem_we_o   <= dma_we_i;
          end
        end

        CPU_ACC, DMA_ACC: begin
          if (cyc_q == ACC_LAST) begin
            if (state_q == CPU_ACC) begin
              cpu_dato_o <= mem_dato_i;
            end else begin
              dma_ack_o <= 1'b1;
              if (!mem_we_o) begin
                dma_dato_o <= mem_dato_i;
              end
            end
            mem_ce_o <= 1'b0;
            mem_oe_o <= 1'b0;
            mem_we_o <= 1'b0;
            cyc_q    <= 4'd0;
            state_q  <= (REC_CYC == 0) ? IDLE : REC;
          end else begin
            cyc_q <= cyc_q + 4'd1;
          end
        end

        REC: begin
          if (cyc_q == REC_LAST) begin
            cyc_q   <= 4'd0;
            state_q <= IDLE;
          end else begin
            cyc_q <= cyc_q + 4'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huc_rom_arb.sv
// tb/tb_huc_rom_arb.sv - directed and randomized bench for huc_rom_arb against a transaction-level memory model
`timescale 1ns/1ps
module tb_huc_rom_arb;

  localparam int MEM_CYC  = 4;
  localparam int REC_CYC  = 1;
  localparam int MAX_WAIT = 8;
  localparam int WIN      = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [20:0] cpu_addr;
  logic        cpu_ce, cpu_oe;
  logic [7:0]  cpu_dato;
  logic        cpu_hit;
  logic        dma_req, dma_we;
  logic [19:0] dma_addr;
  logic [7:0]  dma_dati, dma_dato;
  logic        dma_ack, dma_starve;
  logic [19:0] mem_addr;
  logic [7:0]  mem_dati, mem_dato;
  logic        mem_ce, mem_oe, mem_we;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  mem_arr [0:4095];
  logic [7:0]  ref_arr [0:4095];
  logic        init_mem, poke_en;
  logic [11:0] poke_a;
  logic [7:0]  poke_d;

  logic        ce_h   [1:WIN];
  logic        we_h   [1:WIN];
  logic        ack_h  [1:WIN];
  logic [19:0] addr_h [1:WIN];

  always #5 clk = ~clk;

  huc_rom_arb #(.MEM_CYC(MEM_CYC), .REC_CYC(REC_CYC), .DMA_MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_ce_i(cpu_ce), .cpu_oe_i(cpu_oe),
    .cpu_dato_o(cpu_dato), .cpu_hit_o(cpu_hit),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_dati_i(dma_dati),
    .dma_dato_o(dma_dato), .dma_ack_o(dma_ack), .dma_starve_o(dma_starve),
    .mem_addr_o(mem_addr), .mem_dati_o(mem_dati), .mem_dato_i(mem_dato),
    .mem_ce_o(mem_ce), .mem_oe_o(mem_oe), .mem_we_o(mem_we)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // 4 KB memory device, aliased on the low 12 address bits
  assign mem_dato = mem_arr[mem_addr[11:0]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) mem_arr[i] <= pat(i);
    end else if (poke_en) begin
      mem_arr[poke_a] <= poke_d;
    end else if (mem_ce && mem_we) begin
      mem_arr[mem_addr[11:0]] <= mem_dati;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic watch(input int n, input bit drop);
    for (int k = 1; k <= WIN; k++) begin
      ce_h[k] = 1'b0; we_h[k] = 1'b0; ack_h[k] = 1'b0; addr_h[k] = 20'd0;
    end
    for (int k = 1; k <= n; k++) begin
      step();
      ce_h[k]   = mem_ce;
      we_h[k]   = mem_we;
      ack_h[k]  = dma_ack;
      addr_h[k] = mem_addr;
      if (dma_ack && drop) dma_req = 1'b0;
    end
  endtask

  function automatic logic sel_bit(input int sel, input int k);
    if (sel == 0) return ce_h[k];
    if (sel == 1) return we_h[k];
    return ack_h[k];
  endfunction

  function automatic int cnt_h(input int sel, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(sel_bit(sel, k));
    return c;
  endfunction

  function automatic int first_h(input int sel, input int lo);
    for (int k = lo; k <= WIN; k++) if (sel_bit(sel, k)) return k;
    return WIN + 1;
  endfunction

  function automatic int first_at(input logic [19:0] a);
    for (int k = 1; k <= WIN; k++) if (ce_h[k] && addr_h[k] == a) return k;
    return WIN + 1;
  endfunction

  function automatic int last_at(input logic [19:0] a);
    for (int k = WIN; k >= 1; k--) if (ce_h[k] && addr_h[k] == a) return k;
    return 0;
  endfunction

  initial begin
    int          g, mode, fa, la;
    logic [19:0] ca, da;
    logic [7:0]  dd, exp_cpu, exp_dma;
    logic        dw, we_seen;

    rst = 1'b1; cpu_addr = 21'd0; cpu_ce = 1'b0; cpu_oe = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 20'd0; dma_dati = 8'd0;
    init_mem = 1'b1; poke_en = 1'b0; poke_a = 12'd0; poke_d = 8'd0;
    for (int i = 0; i < 4096; i++) ref_arr[i] = pat(i);
    step();
    init_mem = 1'b0;
    poke_en = 1'b1; poke_a = 12'h123; poke_d = 8'h5A; ref_arr[12'h123] = 8'h5A;
    step();
    poke_en = 1'b0;
    chk("rst_strobes", {27'd0, mem_ce, mem_oe, mem_we, dma_ack, dma_starve}, 32'd0);
    chk("rst_data", {8'd0, cpu_dato, dma_dato, mem_dati}, 32'd0);
    chk("rst_addr", {12'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    step();

    // CPU read, then an access outside ROM space
    cpu_addr = 21'h00123; cpu_oe = 1'b1; cpu_ce = 1'b1;
    #1;
    chk("a_hit", cpu_hit, 1);
    watch(8, 1'b1);
    chk("a_first_ce", first_h(0, 1), 1);
    chk("a_ce_len", cnt_h(0, 1, 8), MEM_CYC);
    chk("a_addr", {ce_h[1], addr_h[1]}, {1'b1, 20'h00123});
    chk("a_no_we", cnt_h(1, 1, 8), 0);
    chk("a_dato", cpu_dato, 8'h5A);
    cpu_ce = 1'b0;
    step();
    cpu_addr = 21'h100123; cpu_ce = 1'b1;
    #1;
    chk("a_nohit", cpu_hit, 0);
    watch(8, 1'b1);
    chk("a_nohit_ce", cnt_h(0, 1, 8), 0);
    cpu_ce = 1'b0;
    step();

    // DMA write held across the ack, giving two back-to-back accesses
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 20'h0FFFF; dma_dati = 8'hA5;
    watch(12, 1'b0);
    dma_req = 1'b0;
    ref_arr[12'hFFF] = 8'hA5;
    chk("b_addr", {ce_h[1], addr_h[1]}, {1'b1, 20'h0FFFF});
    chk("b_we_len", cnt_h(1, 1, 6), MEM_CYC);
    chk("b_ack_first", first_h(2, 1), MEM_CYC + 1);
    chk("b_ack_count", cnt_h(2, 1, 12), 2);
    g = first_h(0, MEM_CYC + 1) - (MEM_CYC + 1);
    chk("b_rec_gap", (g >= REC_CYC && g <= REC_CYC + 1), 1);
    chk("b_mem", mem_arr[12'hFFF], 8'hA5);
    step(); step();

    // Same-clock CPU trigger and DMA read: CPU first
    cpu_addr = 21'h00200; cpu_oe = 1'b1; cpu_ce = 1'b1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 20'h00300;
    watch(16, 1'b1);
    chk("c_cpu_first", {ce_h[1], addr_h[1]}, {1'b1, 20'h00200});
    chk("c_dma_after", first_at(20'h00300) > last_at(20'h00200) + REC_CYC, 1);
    chk("c_ack_count", cnt_h(2, 1, 16), 1);
    chk("c_ack_at_end", first_h(2, 1), last_at(20'h00300) + 1);
    chk("c_cpu_dato", cpu_dato, ref_arr[12'h200]);
    chk("c_dma_dato", dma_dato, ref_arr[12'h300]);
    cpu_ce = 1'b0;
    step(); step();

    // CPU trigger one clock into a DMA read
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 20'h00456;
    step();
    cpu_addr = 21'h00789; cpu_ce = 1'b1;
    watch(16, 1'b1);
    fa = first_at(20'h00789); la = last_at(20'h00789);
    chk("d_cpu_len", la - fa + 1, MEM_CYC);
    chk("d_cpu_after_ack", fa > first_h(2, 1), 1);
    chk("d_latency", la <= 2 * MEM_CYC + 2 * REC_CYC + 1, 1);
    chk("d_cpu_dato", cpu_dato, ref_arr[12'h789]);
    chk("d_dma_dato", dma_dato, ref_arr[12'h456]);
    cpu_ce = 1'b0;
    step(); step();

    // Starvation: CPU retriggers every other clock while a DMA write waits
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 20'h00ABC; dma_dati = 8'h3C;
    cpu_addr = 21'h00111; cpu_oe = 1'b1; cpu_ce = 1'b1;
    we_seen = 1'b0;
    for (int k = 1; k <= MAX_WAIT + 2; k++) begin
      step();
      we_seen = we_seen | mem_we;
      chk($sformatf("e_starve_%0d", k), dma_starve, (k >= MAX_WAIT));
      cpu_ce = ~cpu_ce;
    end
    chk("e_no_grant", we_seen, 0);
    cpu_ce = 1'b0;
    watch(30, 1'b1);
    ref_arr[12'hABC] = 8'h3C;
    chk("e_ack_count", cnt_h(2, 1, 30), 1);
    chk("e_sticky", dma_starve, 1);
    step(); step();
    chk("e_sticky2", dma_starve, 1);
    rst = 1'b1;
    step();
    chk("e_rst_clear", dma_starve, 0);
    rst = 1'b0;
    step();

    // Reset in the second clock of a DMA access
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 20'h00555;
    step(); step();
    chk("f_active", mem_ce, 1);
    #2 rst = 1'b1;
    #1;
    chk("f_strobes", {mem_ce, mem_oe, mem_we, dma_ack}, 4'd0);
    dma_req = 1'b0;
    step();
    rst = 1'b0;
    watch(8, 1'b1);
    chk("f_no_ack", cnt_h(2, 1, 8), 0);
    chk("f_idle", cnt_h(0, 1, 8), 0);

`ifdef HUC_ROM_ARB_SF2_EN
    cpu_addr = 21'h01FF1; cpu_oe = 1'b0; cpu_ce = 1'b1;
    watch(6, 1'b1);
    chk("sf2_bank_wr_no_acc", cnt_h(0, 1, 6), 0);
    cpu_ce = 1'b0; step();
    cpu_addr = 21'h80010; cpu_oe = 1'b1; cpu_ce = 1'b1;
    watch(8, 1'b1);
    chk("sf2_bank1", {ce_h[1], addr_h[1]}, {1'b1, 20'h00010});
    cpu_ce = 1'b0; step();
    cpu_addr = 21'h01FF2; cpu_oe = 1'b0; cpu_ce = 1'b1;
    watch(6, 1'b1);
    cpu_ce = 1'b0; step();
    cpu_addr = 21'h80010; cpu_oe = 1'b1; cpu_ce = 1'b1;
    watch(8, 1'b1);
    chk("sf2_bank2", {ce_h[1], addr_h[1]}, {1'b1, 20'h80010});
    cpu_ce = 1'b0; step();
`endif

    // Randomized transactions against the reference memory
    for (int it = 0; it < 30; it++) begin
      mode = int'($urandom_range(0, 2));
      ca   = 20'($urandom_range(0, 32'h7FFFF));
      da   = 20'($urandom);
      dd   = 8'($urandom);
      dw   = 1'($urandom_range(0, 1));
      if (da == ca) da[0] = ~da[0];
      exp_cpu = ref_arr[ca[11:0]];
      exp_dma = ref_arr[da[11:0]];
      if (mode != 1) begin
        cpu_addr = {1'b0, ca}; cpu_oe = 1'b1; cpu_ce = 1'b1;
      end
      if (mode != 0) begin
        dma_req = 1'b1; dma_we = dw; dma_addr = da; dma_dati = dd;
      end
      watch(20, 1'b1);
      if (mode != 1) begin
        chk("r_cpu_addr", {ce_h[1], addr_h[1]}, {1'b1, ca});
        chk("r_cpu_dato", cpu_dato, exp_cpu);
      end
      if (mode != 0) begin
        chk("r_ack_count", cnt_h(2, 1, 20), 1);
        if (mode == 1) chk("r_dma_grant", first_at(da), 1);
        else chk("r_dma_order", first_at(da) > last_at(ca) + REC_CYC, 1);
        if (dw) begin
          ref_arr[da[11:0]] = dd;
          chk("r_dma_wr", mem_arr[da[11:0]], dd);
        end else begin
          chk("r_dma_dato", dma_dato, exp_dma);
        end
      end else begin
        chk("r_no_ack", cnt_h(2, 1, 20), 0);
      end
      chk("r_we_len", cnt_h(1, 1, 20), (mode != 0 && dw) ? MEM_CYC : 0);
      cpu_ce  = 1'b0;
      dma_req = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
